signed_sub_with_saturation_pipe: RTL and testbench
==================================================

// Module: signed_sub_with_saturation_pipe
// PURPOSE
// - Streaming signed subtractor with saturation: diff = a - b, clamped to the W-bit signed range.
// - Two-stage valid/ready pipeline; the subtract-side companion to the saturating signed adder.
// - Sits between a producer of operand pairs and a consumer of clamped differences.
// PARAMETERS
// - W      4  operand/result width, two's complement, W >= 2
// - CNT_W  8  width of saturation event counter (only with SAT_SUB_COUNT_EN)
// PORTS
// - clk        in   1      clock, all state on rising edge
// - rst_n      in   1      asynchronous, active-low reset
// - up_vld     in   1      operand pair valid
// - up_rdy     out  1      block can accept operand pair
// - a          in   W      minuend, signed
// - b          in   W      subtrahend, signed
// - down_vld   out  1      result valid
// - down_rdy   in   1      consumer accepts result
// - diff       out  W      saturated a - b, signed
// - sat_pos    out  1      result clamped to max positive
// - sat_neg    out  1      result clamped to min negative
// - cnt_clr    in   1      sync clear of sat_cnt (SAT_SUB_COUNT_EN only)
// - sat_cnt    out  CNT_W  accepted saturated results (SAT_SUB_COUNT_EN only)
// BEHAVIOUR
// - Reset (async assert, sync release): both stage valids 0; down_vld, diff, sat_pos, sat_neg, sat_cnt = 0.
// - Reset mid-operation: in-flight data discarded; no output after release until new up_vld.
// - Transfer rule: a beat moves on vld & rdy on the same rising edge.
// - Stage 1 (S1): registers a, b on up_vld & up_rdy.
// - Stage 2 (S2): computes and registers diff / sat flags from S1; drives down_* directly from flops.
// - Latency: 2 cycles from accepted input to down_vld with no backpressure.
// - Throughput: 1 pair per cycle.
// - Ready logic:
//   - s2_free = ~s2_vld | down_rdy
//   - up_rdy  = ~s1_vld | s2_free
//   - up_rdy is combinational from down_rdy; this is allowed.
// - Stall: while down_vld & ~down_rdy, diff / sat_* / down_vld hold stable.
//   - The pipeline fills to 2 entries, then up_rdy = 0.
//   - No beat is dropped, duplicated or reordered.
// - Arithmetic:
//   - raw = a - b mod 2^W
//   - ovf = (a[W-1] != b[W-1]) & (raw[W-1] != a[W-1])
//   - ovf & ~a[W-1] -> diff = 2^(W-1)-1, sat_pos = 1
//   - ovf &  a[W-1] -> diff = -2^(W-1),  sat_neg = 1
//   - otherwise diff = raw and both flags 0
//   - sat_pos & sat_neg are never both 1.
// - Edge case: b = -2^(W-1) with a >= 0 saturates positive; with a < 0 the result is exact.
// CONFIGURATION
// - SAT_SUB_COUNT_EN defined:
//   - sat_cnt increments on each down_vld & down_rdy with sat_pos | sat_neg.
//   - sat_cnt sticks at all-ones (no wrap).
//   - cnt_clr sets it to 0 next edge; clear wins over a simultaneous increment.
// - SAT_SUB_COUNT_EN undefined:
//   - sat_cnt tied to 0, cnt_clr ignored, no counter flops.
//   - Datapath, latency and handshake are identical in both builds.
// TESTING (W=4, CNT_W=2)
// - Basic: a=3, b=5, down_rdy=1 -> 2 cycles later diff=4'hE (-2), sat_pos=0, sat_neg=0.
// - Positive clamp: a=7, b=-1 -> diff=4'h7, sat_pos=1; a=0, b=-8 -> diff=4'h7, sat_pos=1.
// - Negative clamp: a=-8, b=1 -> diff=4'h8, sat_neg=1; a=-1, b=-8 -> diff=4'h7, no flag (exact).
// - Backpressure: stream 1-2, 2-1, 5-5 with down_rdy=0 for 4 cycles.
//   - up_rdy drops after 2 accepted; diff holds -1.
//   - On release, outputs appear -1, 1, 0 in order, one per cycle.
// - Reset mid-stream: assert rst_n=0 with 2 beats in flight.
//   - down_vld=0 immediately (async); after release, nothing emitted until new input.
// - Counter (SAT_SUB_COUNT_EN):
//   - 5 accepted saturating results -> sat_cnt=3 (sticky).
//   - cnt_clr together with a saturating accept -> sat_cnt=0.
//   - Counter-disabled build: sat_cnt stays 0.

Source files
------------

// File: rtl/signed_sub_with_saturation_pipe_if.sv
// Operand/result stream bundle for the saturating signed subtractor.
// The master side produces operand pairs and consumes results; the slave is the pipeline.
interface signed_sub_with_saturation_pipe_if #(
    parameter int W = 4
);
    logic         up_vld;
    logic         up_rdy;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         down_vld;
    logic         down_rdy;
    logic [W-1:0] diff;
    logic         sat_pos;
    logic         sat_neg;

    modport master (
        output up_vld, a, b, down_rdy,
        input  up_rdy, down_vld, diff, sat_pos, sat_neg
    );

    modport slave (
        input  up_vld, a, b, down_rdy,
        output up_rdy, down_vld, diff, sat_pos, sat_neg
    );
endinterface

// File: rtl/signed_sub_with_saturation_pipe.sv
// Two-stage valid/ready streaming subtractor: diff = a - b clamped to the W-bit signed range.
// Define SAT_SUB_COUNT_EN to add a sticky counter of accepted saturated results (sat_cnt).
module signed_sub_with_saturation_pipe #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    signed_sub_with_saturation_pipe_if.slave bus,
    input  logic                             cnt_clr,
    output logic [CNT_W-1:0]                 sat_cnt
);
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic         s1_vld_r;
    logic [W-1:0] s1_a_r;
    logic [W-1:0] s1_b_r;
    logic         s2_vld_r;
    logic [W-1:0] diff_r;
    logic         sat_pos_r;
    logic         sat_neg_r;

    logic         s2_free_s;
    logic         up_rdy_s;
    logic         up_fire_s;
    logic [W-1:0] raw_s;
    logic         ovf_s;
    logic [W-1:0] res_s;
    logic         pos_s;
    logic         neg_s;

    // S2 can take a new beat when empty or when its current beat leaves this edge
    assign s2_free_s = ~s2_vld_r | bus.down_rdy;
    assign up_rdy_s  = ~s1_vld_r | s2_free_s;
    assign up_fire_s = bus.up_vld & up_rdy_s;

    // Saturating subtract of the S1 operands; overflow only possible when signs differ
    always_comb begin
        raw_s = s1_a_r - s1_b_r;
        ovf_s = (s1_a_r[W-1] != s1_b_r[W-1]) && (raw_s[W-1] != s1_a_r[W-1]);
        res_s = raw_s;
        pos_s = 1'b0;
        neg_s = 1'b0;
        if (ovf_s && !s1_a_r[W-1]) begin
            res_s = MAX_POS;
            pos_s = 1'b1;
        end else if (ovf_s) begin
            res_s = MIN_NEG;
            neg_s = 1'b1;
        end else begin
            res_s = raw_s;
            pos_s = 1'b0;
            neg_s = 1'b0;
        end
    end

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_r <= 1'b0;
            s1_a_r   <= {W{1'b0}};
            s1_b_r   <= {W{1'b0}};
        end else if (up_fire_s) begin
            s1_vld_r <= 1'b1;
            s1_a_r   <= bus.a;
            s1_b_r   <= bus.b;
        end else if (s2_free_s) begin
            s1_vld_r <= 1'b0;
        end
    end

    // Stage 2: result register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_r  <= 1'b0;
            diff_r    <= {W{1'b0}};
            sat_pos_r <= 1'b0;
            sat_neg_r <= 1'b0;
        end else if (s2_free_s) begin
            s2_vld_r <= s1_vld_r;
            if (s1_vld_r) begin
                diff_r    <= res_s;
                sat_pos_r <= pos_s;
                sat_neg_r <= neg_s;
            end
        end
    end

    assign bus.up_rdy   = up_rdy_s;
    assign bus.down_vld = s2_vld_r;
    assign bus.diff     = diff_r;
    assign bus.sat_pos  = sat_pos_r;
    assign bus.sat_neg  = sat_neg_r;

`ifdef SAT_SUB_COUNT_EN
    logic [CNT_W-1:0] sat_cnt_r;
    logic             cnt_inc_s;

    assign cnt_inc_s = s2_vld_r & bus.down_rdy & (sat_pos_r | sat_neg_r) & ~(&sat_cnt_r);

    // Sticky saturation counter; clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            sat_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_inc_s) begin
            sat_cnt_r <= sat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign sat_cnt = sat_cnt_r;
`else
    logic unused_cnt_clr_s;

    assign unused_cnt_clr_s = cnt_clr;
    assign sat_cnt          = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_signed_sub_with_saturation_pipe.sv
// Self-checking bench for signed_sub_with_saturation_pipe (W=4, CNT_W=2), both counter builds.
module tb_signed_sub_with_saturation_pipe;
    logic       clk;
    logic       rst_n;
    logic       cnt_clr;
    logic [1:0] sat_cnt;

    signed_sub_with_saturation_pipe_if #(.W(4)) bus ();

    signed_sub_with_saturation_pipe #(.W(4), .CNT_W(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cnt_clr (cnt_clr),
        .sat_cnt (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] diff;
        logic       pos;
        logic       neg;
    } vec_t;

    typedef struct {
        logic [3:0] d;
        logic       p;
        logic       n;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];
    int   model_cnt = 0;
    logic hold_v = 1'b0;
    logic [3:0] hold_d;
    logic hold_p;
    logic hold_n;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: exact integer difference, then clamp to [-8, 7]
    function automatic exp_t ref_sub(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        int   ai;
        int   bi;
        int   d;
        ai = $signed(a);
        bi = $signed(b);
        d  = ai - bi;
        e.p = 1'b0;
        e.n = 1'b0;
        if (d > 7) begin
            e.d = 4'h7;
            e.p = 1'b1;
        end else if (d < -8) begin
            e.d = 4'h8;
            e.n = 1'b1;
        end else begin
            e.d = 4'(d);
        end
        return e;
    endfunction

    // One isolated beat with down_rdy=1; starts and ends just after a rising edge
    task automatic run_vec(input vec_t v, input logic clr_at_out);
        bus.up_vld   = 1'b1;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.down_rdy = 1'b1;
        @(negedge clk);
        chk("vec_up_rdy", bus.up_rdy, 1);
        @(posedge clk);
        #1 bus.up_vld = 1'b0;
        @(negedge clk);
        chk("vec_latency_vld0", bus.down_vld, 0);
        @(posedge clk);
        @(negedge clk);
        chk("vec_vld", bus.down_vld, 1);
        chk("vec_diff", bus.diff, v.diff);
        chk("vec_pos", bus.sat_pos, v.pos);
        chk("vec_neg", bus.sat_neg, v.neg);
        cnt_clr = clr_at_out;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
    endtask

    task automatic chk_cnt(input string nm, input int exp_en);
        @(negedge clk);
`ifdef SAT_SUB_COUNT_EN
        chk(nm, sat_cnt, exp_en);
`else
        chk(nm, sat_cnt, exp_en * 0);
`endif
        @(posedge clk);
        #1;
    endtask

    // One randomized cycle checked against the queue model
    task automatic step(input logic uv, input logic [3:0] ai, input logic [3:0] bi,
                        input logic dr, input logic cc);
        exp_t e;
        logic out_sat;
        bus.up_vld   = uv;
        bus.a        = ai;
        bus.b        = bi;
        bus.down_rdy = dr;
        cnt_clr      = cc;
        @(negedge clk);
        out_sat = 1'b0;
        chk("rnd_sat_cnt", sat_cnt, model_cnt);
        if (hold_v) begin
            chk("stall_vld", bus.down_vld, 1);
            chk("stall_diff", bus.diff, hold_d);
            chk("stall_pos", bus.sat_pos, hold_p);
            chk("stall_neg", bus.sat_neg, hold_n);
        end
        chk("rnd_up_rdy", bus.up_rdy, ((q.size() < 2) || dr) ? 1 : 0);
        if (bus.down_vld && dr) begin
            chk("rnd_q_nonempty", (q.size() > 0) ? 1 : 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rnd_diff", bus.diff, e.d);
                chk("rnd_pos", bus.sat_pos, e.p);
                chk("rnd_neg", bus.sat_neg, e.n);
                out_sat = e.p | e.n;
            end
        end
        if (uv && bus.up_rdy) q.push_back(ref_sub(ai, bi));
        hold_v = bus.down_vld && !dr;
        hold_d = bus.diff;
        hold_p = bus.sat_pos;
        hold_n = bus.sat_neg;
`ifdef SAT_SUB_COUNT_EN
        if (cc) model_cnt = 0;
        else if (out_sat && model_cnt < 3) model_cnt = model_cnt + 1;
`endif
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[11];
    vec_t sat_v;

    initial begin
        vecs[0]  = '{4'h3, 4'h5, 4'hE, 1'b0, 1'b0};
        vecs[1]  = '{4'h7, 4'hF, 4'h7, 1'b1, 1'b0};
        vecs[2]  = '{4'h0, 4'h8, 4'h7, 1'b1, 1'b0};
        vecs[3]  = '{4'h8, 4'h1, 4'h8, 1'b0, 1'b1};
        vecs[4]  = '{4'hF, 4'h8, 4'h7, 1'b0, 1'b0};
        vecs[5]  = '{4'h8, 4'h8, 4'h0, 1'b0, 1'b0};
        vecs[6]  = '{4'h7, 4'h7, 4'h0, 1'b0, 1'b0};
        vecs[7]  = '{4'h9, 4'h2, 4'h8, 1'b0, 1'b1};
        vecs[8]  = '{4'h6, 4'hD, 4'h7, 1'b1, 1'b0};
        vecs[9]  = '{4'h5, 4'hE, 4'h7, 1'b0, 1'b0};
        vecs[10] = '{4'hA, 4'h2, 4'h8, 1'b0, 1'b0};
        sat_v    = '{4'h7, 4'hF, 4'h7, 1'b1, 1'b0};

        rst_n        = 1'b0;
        cnt_clr      = 1'b0;
        bus.up_vld   = 1'b0;
        bus.a        = 4'h0;
        bus.b        = 4'h0;
        bus.down_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_down_vld", bus.down_vld, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_sat_pos", bus.sat_pos, 0);
        chk("rst_sat_neg", bus.sat_neg, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        chk("rst_up_rdy", bus.up_rdy, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Arithmetic table (5 saturating entries saturate the 2-bit counter)
        for (int i = 0; i < 11; i++) run_vec(vecs[i], 1'b0);
        chk_cnt("cnt_after_table", 3);

        // Counter clear, increment, stick, and clear-beats-increment
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        chk_cnt("cnt_clr", 0);
        run_vec(sat_v, 1'b0);
        chk_cnt("cnt_one", 1);
        for (int i = 0; i < 4; i++) run_vec(sat_v, 1'b0);
        chk_cnt("cnt_sticky", 3);
        run_vec(sat_v, 1'b1);
        chk_cnt("cnt_clr_wins", 0);

        // Backpressure: 1-2, 2-1, 5-5 with the consumer stalled
        bus.down_rdy = 1'b0;
        bus.up_vld   = 1'b1;
        bus.a        = 4'h1;
        bus.b        = 4'h2;
        @(negedge clk);
        chk("bp_up_rdy0", bus.up_rdy, 1);
        @(posedge clk);
        #1 bus.a = 4'h2;
        bus.b = 4'h1;
        @(negedge clk);
        chk("bp_up_rdy1", bus.up_rdy, 1);
        chk("bp_vld_early", bus.down_vld, 0);
        @(posedge clk);
        #1 bus.a = 4'h5;
        bus.b = 4'h5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_full_up_rdy", bus.up_rdy, 0);
            chk("bp_hold_vld", bus.down_vld, 1);
            chk("bp_hold_diff", bus.diff, 4'hF);
            @(posedge clk);
        end
        #1 bus.down_rdy = 1'b1;
        @(negedge clk);
        chk("bp_release_up_rdy", bus.up_rdy, 1);
        chk("bp_out0", bus.diff, 4'hF);
        @(posedge clk);
        #1 bus.up_vld = 1'b0;
        @(negedge clk);
        chk("bp_out1_vld", bus.down_vld, 1);
        chk("bp_out1", bus.diff, 4'h1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_out2_vld", bus.down_vld, 1);
        chk("bp_out2", bus.diff, 4'h0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_empty", bus.down_vld, 0);
        @(posedge clk);
        #1;

        // Reset with two beats in flight
        bus.down_rdy = 1'b0;
        bus.up_vld   = 1'b1;
        bus.a        = 4'h3;
        bus.b        = 4'h1;
        @(posedge clk);
        #1 bus.a = 4'h4;
        @(posedge clk);
        #1 bus.up_vld = 1'b0;
        @(negedge clk);
        chk("rm_pre_vld", bus.down_vld, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_async_vld", bus.down_vld, 0);
        chk("rm_async_diff", bus.diff, 0);
        chk("rm_async_up_rdy", bus.up_rdy, 1);
        @(posedge clk);
        #1 bus.down_rdy = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rm_no_output", bus.down_vld, 0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic against the queue model, then drain
        model_cnt = 0;
        hold_v    = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
        chk("drain_q_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
